// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: round-robin arbitration in front of a single APB slave,
// with SETUP/ACCESS sequencing, PREADY wait states and a programmable ACCESS timeout.
module apb_req_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_done,
  output logic                    req_err,
  output logic [DATA_WIDTH-1:0]   req_rdata,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // A zero TIMEOUT still needs a 1-bit counter; it saturates instead of wrapping.
  localparam int                CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t                  r_state, w_state_nxt;
  logic                    r_gnt, w_gnt_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic                    r_psel, w_psel_nxt;
  logic                    r_penable, w_penable_nxt;
  logic                    r_pwrite, w_pwrite_nxt;
  logic [ADDR_WIDTH-1:0]   r_paddr, w_paddr_nxt;
  logic [DATA_WIDTH-1:0]   r_pwdata, w_pwdata_nxt;
  logic [1:0]              r_done, w_done_nxt;
  logic                    r_err, w_err_nxt;
  logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;

  logic                    w_pick;
  logic                    w_pick_write;
  logic [ADDR_WIDTH-1:0]   w_pick_addr;
  logic [DATA_WIDTH-1:0]   w_pick_wdata;
  logic                    w_timeout;

  // On a tie the requester that did not win last time is chosen.
  assign w_pick       = (req_valid == 2'b11) ? ~r_gnt : req_valid[1];
  assign w_pick_write = w_pick ? req_write[1] : req_write[0];
  assign w_pick_addr  = w_pick ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                               : req_addr[ADDR_WIDTH-1:0];
  assign w_pick_wdata = w_pick ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                               : req_wdata[DATA_WIDTH-1:0];
  assign w_timeout    = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_cnt_nxt     = r_cnt;
    w_psel_nxt    = r_psel;
    w_penable_nxt = r_penable;
    w_pwrite_nxt  = r_pwrite;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;
    w_done_nxt    = 2'b00;
    w_err_nxt     = 1'b0;
    w_rdata_nxt   = r_rdata;

    unique case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          w_state_nxt   = S_SETUP;
          w_gnt_nxt     = w_pick;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_pwrite_nxt  = w_pick_write;
          w_paddr_nxt   = w_pick_addr;
          w_pwdata_nxt  = w_pick_write ? w_pick_wdata : '0;
        end
      end

      S_SETUP: begin
        w_state_nxt   = S_ACCESS;
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
      end

      S_ACCESS: begin
        if (PREADY || w_timeout) begin
          w_state_nxt   = S_DONE;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_pwdata_nxt  = '0;
          w_done_nxt    = r_gnt ? 2'b10 : 2'b01;
          w_err_nxt     = ~PREADY;
          if (PREADY && !r_pwrite) begin
            w_rdata_nxt = PRDATA;
          end
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= S_IDLE;
      r_gnt     <= 1'b1;
      r_cnt     <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_done    <= 2'b00;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_cnt     <= w_cnt_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_rdata   <= w_rdata_nxt;
    end
  end

  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign req_done  = r_done;
  assign req_err   = r_err;
  assign req_rdata = r_rdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed plus randomized bench for apb_req_arbiter: a transfer-level model (arbitration
// rule, slave memory, expected read data) predicts every APB and requester-side output.
module tb_apb_req_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  logic [1:0]    req_done;
  logic          req_err;
  logic [DW-1:0] req_rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;

  // Second instance with the timeout disabled, sharing all inputs.
  logic [1:0]    z_req_done;
  logic          z_req_err;
  logic [DW-1:0] z_req_rdata;
  logic          z_psel, z_penable, z_pwrite;
  logic [AW-1:0] z_paddr;
  logic [DW-1:0] z_pwdata;

  apb_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  apb_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) dut_noto (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(z_req_done), .req_err(z_req_err), .req_rdata(z_req_rdata),
    .PSEL(z_psel), .PENABLE(z_penable), .PWRITE(z_pwrite), .PADDR(z_paddr), .PWDATA(z_pwdata),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: slave memory, last granted requester, expected read data.
  logic [DW-1:0] mem [256];
  bit            m_last;
  logic [DW-1:0] m_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic model_reset();
    m_last  = 1'b1;
    m_rdata = '0;
  endtask

  function automatic bit pick(input logic [1:0] v, input bit last);
    if (v == 2'b11) return !last;
    return v[1];
  endfunction

  task automatic set_req(input int who, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_write[who]          = wr;
    req_addr[who*AW +: AW]  = a;
    req_wdata[who*DW +: DW] = d;
  endtask

  // One step expected to leave/keep the block idle with no completion.
  task automatic idle_step(input string tag);
    step();
    check({tag, " psel"}, 64'(PSEL), 64'(0));
    check({tag, " penable"}, 64'(PENABLE), 64'(0));
    check({tag, " done"}, 64'(req_done), 64'(0));
  endtask

  // Runs one transfer from IDLE (requests already driven) and returns in the DONE cycle.
  task automatic run_txn(input int waits, input logic [1:0] drop);
    bit            g;
    int            gi;
    bit            wr;
    bit            to;
    int            n_acc;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_pwdata;
    g          = pick(req_valid, m_last);
    gi         = g ? 1 : 0;
    wr         = req_write[gi];
    a          = req_addr[gi*AW +: AW];
    wd         = req_wdata[gi*DW +: DW];
    exp_pwdata = wr ? wd : '0;
    m_last     = g;
    to         = (waits >= TO);
    n_acc      = to ? TO : waits + 1;

    PREADY = 1'($urandom);
    step();
    check("setup psel", 64'(PSEL), 64'(1));
    check("setup penable", 64'(PENABLE), 64'(0));
    check("setup paddr", 64'(PADDR), 64'(a));
    check("setup pwrite", 64'(PWRITE), 64'(wr));
    check("setup pwdata", 64'(PWDATA), 64'(exp_pwdata));
    check("setup done", 64'(req_done), 64'(0));
    req_valid = req_valid & ~drop;
    PREADY    = 1'b1;
    step();
    for (int c = 1; c <= n_acc; c++) begin
      check("access psel", 64'(PSEL), 64'(1));
      check("access penable", 64'(PENABLE), 64'(1));
      check("access paddr", 64'(PADDR), 64'(a));
      check("access pwdata", 64'(PWDATA), 64'(exp_pwdata));
      check("access done", 64'(req_done), 64'(0));
      PREADY = !to && (c == n_acc);
      PRDATA = (PREADY && !wr) ? mem[a] : $urandom;
      step();
    end
    PREADY = 1'b0;
    if (!to && wr) mem[a] = wd;
    if (!to && !wr) m_rdata = mem[a];
    check("done pulse", 64'(req_done), g ? 64'(2) : 64'(1));
    check("done err", 64'(req_err), 64'(to));
    check("done rdata", 64'(req_rdata), 64'(m_rdata));
    check("done psel", 64'(PSEL), 64'(0));
    check("done penable", 64'(PENABLE), 64'(0));
    check("done pwdata", 64'(PWDATA), 64'(0));
    check("done paddr hold", 64'(PADDR), 64'(a));
    check("done pwrite hold", 64'(PWRITE), 64'(wr));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            seen;
    logic [1:0]    v;
    int            r;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    PRESETn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    model_reset();
    step();
    step();
    check("rst psel", 64'(PSEL), 64'(0));
    check("rst penable", 64'(PENABLE), 64'(0));
    check("rst pwrite", 64'(PWRITE), 64'(0));
    check("rst paddr", 64'(PADDR), 64'(0));
    check("rst pwdata", 64'(PWDATA), 64'(0));
    check("rst done", 64'(req_done), 64'(0));
    check("rst err", 64'(req_err), 64'(0));
    check("rst rdata", 64'(req_rdata), 64'(0));
    PRESETn = 1'b1;

    // Single write then read by requester 0.
    set_req(0, 1'b1, 8'h3C, 32'hDEADBEEF);
    req_valid = 2'b01;
    run_txn(0, 2'b00);
    set_req(0, 1'b0, 8'h3C, 32'h0);
    idle_step("wr->idle");
    run_txn(0, 2'b00);
    check("read back", 64'(req_rdata), 64'h00000000DEADBEEF);
    req_valid = 2'b00;
    idle_step("rd->idle");

    // Three wait states, requester 1 reads the same location.
    set_req(1, 1'b0, 8'h3C, 32'h0);
    req_valid = 2'b10;
    run_txn(3, 2'b00);
    req_valid = 2'b00;
    idle_step("wait->idle");

    // Withdrawal: r1 drops its request while r0 is being served.
    set_req(0, 1'b1, 8'h40, 32'h12345678);
    set_req(1, 1'b1, 8'h41, 32'h55555555);
    req_valid = 2'b11;
    run_txn(0, 2'b10);
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) idle_step("withdraw idle");

    // Timeout: PREADY held low on a read; prior read data must survive.
    set_req(0, 1'b0, 8'h3C, 32'h0);
    req_valid = 2'b01;
    run_txn(100, 2'b00);
    req_valid = 2'b00;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      seen = seen | (|z_req_done);
    end
    check("noto never done", 64'(seen), 64'(0));
    check("noto psel", 64'(z_psel), 64'(1));
    check("noto penable", 64'(z_penable), 64'(1));
    check("to idle psel", 64'(PSEL), 64'(0));

    // Reset in the middle of ACCESS (both instances are in ACCESS).
    set_req(1, 1'b0, 8'h3C, 32'h0);
    req_valid = 2'b10;
    step();
    check("mid setup psel", 64'(PSEL), 64'(1));
    step();
    step();
    check("mid access penable", 64'(PENABLE), 64'(1));
    #3;
    PRESETn = 1'b0;
    #1;
    check("async psel", 64'(PSEL), 64'(0));
    check("async penable", 64'(PENABLE), 64'(0));
    check("async done", 64'(req_done), 64'(0));
    check("async rdata", 64'(req_rdata), 64'(0));
    check("async noto psel", 64'(z_psel), 64'(0));
    check("async noto penable", 64'(z_penable), 64'(0));
    model_reset();
    req_valid = 2'b00;
    step();
    PRESETn = 1'b1;
    for (int k = 0; k < 3; k++) idle_step("post-rst idle");

    // Reset during the DONE cycle clears the pulse at once.
    set_req(0, 1'b1, 8'h77, 32'hA5A5F00D);
    req_valid = 2'b01;
    run_txn(0, 2'b00);
    req_valid = 2'b00;
    #3;
    PRESETn = 1'b0;
    #1;
    check("async done in DONE", 64'(req_done), 64'(0));
    check("async paddr", 64'(PADDR), 64'(0));
    check("async pwrite", 64'(PWRITE), 64'(0));
    model_reset();
    step();
    PRESETn = 1'b1;
    idle_step("post-rst2 idle");

    // Contention from reset: persistent requests alternate starting with r0.
    set_req(0, 1'b1, 8'h10, 32'h1111_0000);
    set_req(1, 1'b1, 8'h20, 32'h2222_0000);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      run_txn(0, 2'b00);
      idle_step("contention done->idle");
    end
    req_valid = 2'b00;
    idle_step("contention end");

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      v = 2'($urandom_range(0, 3));
      for (int w = 0; w < 2; w++)
        set_req(w, 1'($urandom), 8'($urandom_range(0, 7)), $urandom);
      req_valid = v;
      if (v == 2'b00) begin
        idle_step("rand idle");
      end else begin
        r = $urandom_range(0, 9);
        run_txn((r == 9) ? TO : (r % 4), 2'b00);
        req_valid = 2'b00;
        idle_step("rand done->idle");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
